// File: rtl/gr_pkg.sv
// Shared definitions for the general-register file: clear/ready state encoding,
// default geometry and a constant log2 helper for index widths.
package gr_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } gr_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gen_gr_mp_if.sv
// Decode/writeback-facing bundle of the register file: read ports, write port,
// scoreboard set, re-clear request and busy status.
interface gen_gr_mp_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NRP  = 3
);
    logic [NRP-1:0]      rs_req;
    logic [NRP*AW-1:0]   rs_n;
    logic [NRP*XLEN-1:0] rs_data;
    logic [NRP-1:0]      rs_pend;
    logic                rd;
    logic [AW-1:0]       rd_n;
    logic [XLEN-1:0]     wd;
    logic                sb_set;
    logic [AW-1:0]       sb_set_n;
    logic                clr_req;
    logic                busy;

    modport master (
        output rs_req, rs_n, rd, rd_n, wd, sb_set, sb_set_n, clr_req,
        input  rs_data, rs_pend, busy
    );

    modport slave (
        input  rs_req, rs_n, rd, rd_n, wd, sb_set, sb_set_n, clr_req,
        output rs_data, rs_pend, busy
    );
endinterface

// File: rtl/gen_gr_sb.sv
// Pending-write scoreboard: one bit per register, set at issue and cleared by the
// completing write, with per-port lookup that treats a same-cycle write as resolved.
module gen_gr_sb
    import gr_pkg::*;
#(
    parameter int NREG    = NREG_DEF,
    parameter int AW      = clog2(NREG),
    parameter int NRP     = 3,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic              m_clock,
    input  logic              p_reset,
    input  logic              ready,
    input  logic              flush,
    input  logic              rd,
    input  logic [AW-1:0]     rd_n,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_set_n,
    input  logic [NRP-1:0]    rs_req,
    input  logic [NRP*AW-1:0] rs_n,
    output logic [NRP-1:0]    rs_pend
);

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;
    logic            set_ok;

    assign set_ok = sb_set && !((ZERO_R0 != 0) && (sb_set_n == '0));

    // Set is applied after clear so a new producer supersedes the retiring one.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else if (ready) begin
            if (rd) begin
                pend_d[rd_n] = 1'b0;
            end
            if (set_ok) begin
                pend_d[sb_set_n] = 1'b1;
            end
        end
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    for (genvar i = 0; i < NRP; i++) begin : g_look
        logic [AW-1:0] idx;
        logic          is_r0;
        logic          wr_hit;

        assign idx        = rs_n[i*AW +: AW];
        assign is_r0      = (ZERO_R0 != 0) && (idx == '0);
        assign wr_hit     = (BYPASS != 0) && rd && (rd_n == idx);
        assign rs_pend[i] = ready && rs_req[i] && pend_q[idx] && !wr_hit && !is_r0;
    end

endmodule

// File: rtl/gen_gr_mp.sv
// RV32I general-register file: NRP combinational read ports, one write port with
// optional bypass, hardwired r0, pending-write scoreboard and post-reset zero-fill.
module gen_gr_mp
    import gr_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREG    = NREG_DEF,
    parameter int AW      = clog2(NREG),
    parameter int NRP     = 3,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic        m_clock,
    input  logic        p_reset,
    gen_gr_mp_if.slave  bus
);

    gr_state_e       state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] gr_q [NREG];

    logic            ready;
    logic            flush;
    logic            wr_ok;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;

    assign ready    = (state_q == S_READY);
    assign bus.busy = (state_q == S_CLEAR);
    assign wr_ok    = bus.rd && !((ZERO_R0 != 0) && (bus.rd_n == '0));

    // The clear sequencer owns the write port while busy; clr_req beats a same-cycle write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        waddr   = bus.rd_n;
        wdata   = bus.wd;
        flush   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                we    = 1'b1;
                waddr = cnt_q;
                wdata = '0;
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(NREG - 1)) begin
                    state_d = S_READY;
                    cnt_d   = '0;
                end
            end
            S_READY: begin
                if (bus.clr_req) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                    flush   = 1'b1;
                end else if (wr_ok) begin
                    we = 1'b1;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Array contents are deliberately unreset; the clear sequence zero-fills them.
    always_ff @(posedge m_clock) begin
        if (we) begin
            gr_q[waddr] <= wdata;
        end
    end

    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] rdata;

        assign idx = bus.rs_n[i*AW +: AW];

        always_comb begin
            rdata = '0;
            if (ready && bus.rs_req[i]) begin
                if ((ZERO_R0 != 0) && (idx == '0)) begin
                    rdata = '0;
                end else if ((BYPASS != 0) && bus.rd && (bus.rd_n == idx)) begin
                    rdata = bus.wd;
                end else begin
                    rdata = gr_q[idx];
                end
            end
        end

        assign bus.rs_data[i*XLEN +: XLEN] = rdata;
    end

    gen_gr_sb #(
        .NREG    (NREG),
        .AW      (AW),
        .NRP     (NRP),
        .ZERO_R0 (ZERO_R0),
        .BYPASS  (BYPASS)
    ) u_sb (
        .m_clock  (m_clock),
        .p_reset  (p_reset),
        .ready    (ready),
        .flush    (flush),
        .rd       (bus.rd),
        .rd_n     (bus.rd_n),
        .sb_set   (bus.sb_set),
        .sb_set_n (bus.sb_set_n),
        .rs_req   (bus.rs_req),
        .rs_n     (bus.rs_n),
        .rs_pend  (bus.rs_pend)
    );

endmodule

// File: tb/tb_gen_gr_mp.sv
// Bench for gen_gr_mp: directed scenarios followed by random traffic, all checked
// against a behavioural register-file model held in arrays.
module tb_gen_gr_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int NRP  = 3;

    logic m_clock = 1'b0;
    logic p_reset;

    always #5 m_clock = ~m_clock;

    gen_gr_mp_if #(.XLEN(XLEN), .AW(AW), .NRP(NRP)) bus ();

    gen_gr_mp #(
        .XLEN(XLEN), .NREG(NREG), .AW(AW), .NRP(NRP), .ZERO_R0(1), .BYPASS(1)
    ) dut (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0] m_gr   [NREG];
    bit              m_pend [NREG];
    int              clear_left;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_wipe();
        clear_left = NREG;
        for (int r = 0; r < NREG; r++) begin
            m_gr[r]   = '0;
            m_pend[r] = 1'b0;
        end
    endtask

    function automatic int port_n(input int i);
        return int'(bus.rs_n[i*AW +: AW]);
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input int i);
        int n;
        n = port_n(i);
        if (clear_left > 0 || !bus.rs_req[i] || n == 0) return '0;
        if (bus.rd && int'(bus.rd_n) == n) return bus.wd;
        return m_gr[n];
    endfunction

    function automatic logic exp_pend(input int i);
        int n;
        n = port_n(i);
        if (clear_left > 0 || !bus.rs_req[i] || n == 0) return 1'b0;
        if (bus.rd && int'(bus.rd_n) == n) return 1'b0;
        return m_pend[n];
    endfunction

    task automatic tick();
        if (p_reset) begin
            if (clear_left > 0) begin
                clear_left--;
            end else if (bus.clr_req) begin
                model_wipe();
            end else begin
                if (bus.rd && bus.rd_n != 0) m_gr[bus.rd_n] = bus.wd;
                if (bus.rd) m_pend[bus.rd_n] = 1'b0;
                if (bus.sb_set && bus.sb_set_n != 0) m_pend[bus.sb_set_n] = 1'b1;
            end
        end
        @(posedge m_clock);
        #1;
    endtask

    task automatic set_port(input int i, input bit req, input int n);
        bus.rs_req[i]          = req;
        bus.rs_n[i*AW +: AW]   = AW'(n);
    endtask

    task automatic read_all(input int n);
        for (int i = 0; i < NRP; i++) set_port(i, 1'b1, n);
    endtask

    task automatic idle();
        bus.rs_req   = '0;
        bus.rs_n     = '0;
        bus.rd       = 1'b0;
        bus.rd_n     = '0;
        bus.wd       = '0;
        bus.sb_set   = 1'b0;
        bus.sb_set_n = '0;
        bus.clr_req  = 1'b0;
    endtask

    task automatic check_all(input string tag);
        #1;
        for (int i = 0; i < NRP; i++) begin
            chk($sformatf("%s_data%0d", tag, i), bus.rs_data[i*XLEN +: XLEN], exp_data(i));
            chk($sformatf("%s_pend%0d", tag, i), 32'(bus.rs_pend[i]), 32'(exp_pend(i)));
        end
        chk($sformatf("%s_busy", tag), 32'(bus.busy), 32'(clear_left > 0));
    endtask

    task automatic wait_clear(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    int nbusy;

    initial begin
        p_reset = 1'b0;
        idle();
        model_wipe();
        repeat (3) tick();
        chk("rst_busy", 32'(bus.busy), 32'd1);
        check_all("rst");

        // Release reset while trying to write and mark x3 during the clear.
        p_reset = 1'b1;
        bus.rd = 1'b1; bus.rd_n = 5'd3; bus.wd = 32'hFFFF_FFFF;
        bus.sb_set = 1'b1; bus.sb_set_n = 5'd3;
        wait_clear(nbusy);
        chk("boot_busy_cycles", 32'(nbusy), 32'd32);
        idle();
        check_all("ready");
        read_all(3);
        check_all("x3_after_busy_write");
        chk("x3_zero", bus.rs_data[XLEN-1:0], 32'h0);
        chk("x3_not_pend", 32'(bus.rs_pend[0]), 32'd0);

        for (int n = 0; n < NREG; n++) begin
            read_all(n);
            check_all($sformatf("zero_r%0d", n));
        end

        // Write x5 and read it back on every port.
        idle();
        bus.rd = 1'b1; bus.rd_n = 5'd5; bus.wd = 32'hDEAD_BEEF;
        tick();
        idle();
        read_all(5);
        #1;
        for (int i = 0; i < NRP; i++)
            chk($sformatf("x5_port%0d", i), bus.rs_data[i*XLEN +: XLEN], 32'hDEAD_BEEF);
        check_all("x5_read");
        bus.rd = 1'b1; bus.rd_n = 5'd5; bus.wd = 32'h0000_1234;
        #1;
        chk("x5_bypass", bus.rs_data[XLEN-1:0], 32'h0000_1234);
        check_all("x5_bypass");
        tick();

        // r0 is hardwired: write and scoreboard set are both ignored.
        idle();
        bus.rd = 1'b1; bus.rd_n = 5'd0; bus.wd = 32'hFFFF_FFFF;
        read_all(0);
        #1;
        chk("x0_bypass_blocked", bus.rs_data[XLEN-1:0], 32'h0);
        tick();
        idle();
        read_all(0);
        #1;
        chk("x0_read", bus.rs_data[XLEN-1:0], 32'h0);
        bus.sb_set = 1'b1; bus.sb_set_n = 5'd0;
        tick();
        bus.sb_set = 1'b0;
        #1;
        chk("x0_pend", 32'(bus.rs_pend[0]), 32'd0);
        check_all("x0");

        // Scoreboard set, resolve by write, and set-wins on collision.
        idle();
        bus.sb_set = 1'b1; bus.sb_set_n = 5'd7;
        tick();
        idle();
        read_all(7);
        #1;
        chk("x7_pend_set", 32'(bus.rs_pend[1]), 32'd1);
        bus.rd = 1'b1; bus.rd_n = 5'd7; bus.wd = 32'hCAFE_0007;
        #1;
        chk("x7_pend_resolved", 32'(bus.rs_pend[1]), 32'd0);
        chk("x7_data_fwd", bus.rs_data[XLEN +: XLEN], 32'hCAFE_0007);
        check_all("x7_write");
        tick();
        bus.rd = 1'b0;
        #1;
        chk("x7_pend_after", 32'(bus.rs_pend[2]), 32'd0);
        chk("x7_data_after", bus.rs_data[2*XLEN +: XLEN], 32'hCAFE_0007);
        bus.sb_set = 1'b1; bus.sb_set_n = 5'd9;
        bus.rd = 1'b1; bus.rd_n = 5'd9; bus.wd = 32'h0000_0009;
        tick();
        idle();
        read_all(9);
        #1;
        chk("x9_set_wins", 32'(bus.rs_pend[0]), 32'd1);
        check_all("x9");

        // Load some registers and a pending bit, then re-clear.
        for (int r = 1; r <= 4; r++) begin
            bus.rd = 1'b1; bus.rd_n = AW'(r); bus.wd = 32'h1111_1111 * r;
            tick();
        end
        idle();
        bus.sb_set = 1'b1; bus.sb_set_n = 5'd12;
        tick();
        idle();
        bus.clr_req = 1'b1;
        bus.rd = 1'b1; bus.rd_n = 5'd6; bus.wd = 32'h6666_6666;
        tick();
        idle();
        wait_clear(nbusy);
        chk("clr_busy_cycles", 32'(nbusy), 32'd32);
        for (int n = 0; n < NREG; n++) begin
            read_all(n);
            check_all($sformatf("clr_r%0d", n));
        end
        read_all(12);
        #1;
        chk("x12_pend_flushed", 32'(bus.rs_pend[0]), 32'd0);
        read_all(6);
        #1;
        chk("x6_write_discarded", bus.rs_data[XLEN-1:0], 32'h0);

        // Reset asserted part way through a clear restarts it from the beginning.
        idle();
        bus.clr_req = 1'b1;
        tick();
        idle();
        repeat (10) tick();
        chk("midclr_busy", 32'(bus.busy), 32'd1);
        p_reset = 1'b0;
        model_wipe();
        #2;
        chk("midclr_rst_busy", 32'(bus.busy), 32'd1);
        p_reset = 1'b1;
        wait_clear(nbusy);
        chk("midclr_restart_cycles", 32'(nbusy), 32'd32);
        check_all("after_restart");

        // Random traffic over a small register window to provoke collisions.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NRP; i++)
                set_port(i, 1'($urandom_range(0, 3) != 0), $urandom_range(0, 11));
            bus.rd       = 1'($urandom_range(0, 1));
            bus.rd_n     = AW'($urandom_range(0, 11));
            bus.wd       = $urandom;
            bus.sb_set   = 1'($urandom_range(0, 1));
            bus.sb_set_n = AW'($urandom_range(0, 11));
            bus.clr_req  = 1'($urandom_range(0, 63) == 0);
            check_all($sformatf("rnd%0d", c));
            tick();
        end

        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
